// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared colours, pixel bundle and pipeline latency for the trace renderer
package trace_pkg;

    typedef logic [11:0] rgb_t;

    localparam rgb_t TRACE_COLOR = 12'hFFF;
    localparam rgb_t EDGE_COLOR  = 12'h0F0;
    localparam rgb_t GRID_COLOR  = 12'h333;
    localparam rgb_t BG_COLOR    = 12'h000;

    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic        video_on;
        logic [10:0] y;
        logic [10:0] x;
    } pix_t;

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - fixed-depth shift-register delay line with asynchronous active-low clear
module sync_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/trace_renderer.sv
// rtl/trace_renderer.sv - three-stage digital trace pixel renderer fed by a scrolling sample store
// Dotted column grid is only built when TRACE_GRID_EN is defined.
module trace_renderer
    import trace_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int H_ACTIVE   = 480,
    parameter int Y_HIGH     = 100,
    parameter int Y_LOW      = 200
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           x,
    input  logic [10:0]           y,
    input  logic                  video_on,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    output logic [ADDR_WIDTH-1:0] addr_r,
    input  logic                  sample,
    output logic [11:0]           rgb,
    output logic                  hsync,
    output logic                  vsync
);

    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] Y_HI  = 11'(Y_HIGH);
    localparam logic [10:0] Y_LO  = 11'(Y_LOW);

    pix_t       pix_in;
    pix_t       pix2;
    logic [1:0] sync_in;
    logic [1:0] sync_out;
    rgb_t       rgb_next;
    logic       prev_sample;
    logic       prev_eff;
    logic       col_active;
    logic       in_band;
    logic       on_level;
    logic       edge_hit;

    // Stage 1: columns beyond the drawn area park the store address at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r <= '0;
        end else if (x < H_LIM) begin
            addr_r <= x[ADDR_WIDTH-1:0];
        end else begin
            addr_r <= '0;
        end
    end

    assign pix_in  = '{video_on: video_on, y: y, x: x};
    assign sync_in = {hsync_in, vsync_in};

    sync_delay #(.WIDTH($bits(pix_t)), .DEPTH(PIPE_LAT - 1)) u_pix_dly (
        .clk   (clk),
        .reset (reset),
        .din   (pix_in),
        .dout  (pix2)
    );

    sync_delay #(.WIDTH(2), .DEPTH(PIPE_LAT)) u_sync_dly (
        .clk   (clk),
        .reset (reset),
        .din   (sync_in),
        .dout  (sync_out)
    );

    assign hsync = sync_out[1];
    assign vsync = sync_out[0];

    // Stage 2: column 0 compares against itself so no edge appears at the left border.
    always_comb begin
        col_active = (pix2.x < H_LIM);
        prev_eff   = (pix2.x == '0) ? sample : prev_sample;
        in_band    = (pix2.y >= Y_HI) && (pix2.y <= Y_LO);
        on_level   = sample ? (pix2.y == Y_HI) : (pix2.y == Y_LO);
        edge_hit   = col_active && (sample != prev_eff) && in_band;

        rgb_next = BG_COLOR;
        if (!pix2.video_on) begin
            rgb_next = '0;
        end else if (edge_hit) begin
            rgb_next = EDGE_COLOR;
        end else if (col_active && on_level) begin
            rgb_next = TRACE_COLOR;
        end
`ifdef TRACE_GRID_EN
        else if (col_active && (pix2.x[4:0] == 5'd0) && !pix2.y[0]) begin
            rgb_next = GRID_COLOR;
        end
`endif
    end

    // Stage 3
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb         <= '0;
            prev_sample <= 1'b0;
        end else begin
            rgb <= rgb_next;
            if (col_active) begin
                prev_sample <= sample;
            end
        end
    end

endmodule

// File: tb/tb_trace_renderer.sv
// tb/tb_trace_renderer.sv - scoreboard bench for trace_renderer
module tb_trace_renderer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] x = '0;
    logic [10:0] y = '0;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        sample = 1'b0;
    logic [8:0]  addr_r;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;

    trace_renderer dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .y        (y),
        .video_on (video_on),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .addr_r   (addr_r),
        .sample   (sample),
        .rgb      (rgb),
        .hsync    (hsync),
        .vsync    (vsync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic [8:0]  addr;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        act_q[$];
    logic        mem [512];
    logic [8:0]  last_addr = '0;
    logic        m_prev = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [11:0] model(input int px, input int py, input logic von,
                                         input logic s, input logic pv);
        logic p;
        p = pv;
        if (!von) return 12'h000;
        if (px >= 480) return 12'h000;
        if (px == 0) p = s;
        if (s != p && py >= 100 && py <= 200) return 12'h0F0;
        if ((s && py == 100) || (!s && py == 200)) return 12'hFFF;
`ifdef TRACE_GRID_EN
        if (px % 32 == 0 && py % 2 == 0) return 12'h333;
`endif
        return 12'h000;
    endfunction

    // One pixel clock: record outputs, model a registered store read, drive the next pixel.
    task automatic step(input int px, input int py, input logic von, input logic hs,
                        input logic vs, input logic [11:0] erg);
        ent_t a;
        ent_t e;
        @(negedge clk);
        a.rgb = rgb; a.hs = hsync; a.vs = vsync; a.addr = addr_r;
        act_q.push_back(a);
        sample    = mem[last_addr];
        last_addr = addr_r;
        x = 11'(px); y = 11'(py); video_on = von; hsync_in = hs; vsync_in = vs;
        e.rgb = erg; e.hs = hs; e.vs = vs; e.addr = (px < 480) ? 9'(px) : 9'd0;
        exp_q.push_back(e);
        if (px < 480) m_prev = mem[px];
    endtask

    task automatic flush();
        repeat (3) step(600, 0, 1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rgb, hsync, vsync, addr_r} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_state: rgb=%h hs=%b vs=%b addr=%0d, want all 0", rgb, hsync, vsync, addr_r);
        end
        @(negedge clk);
        reset = 1'b1;
        mem[0] = 1'b1;
        repeat (4) step(0, 100, 1'b1, 1'b1, 1'b1, 12'hFFF);
        #2 reset = 1'b0;
        m_prev = 1'b0;
        #1;
        n_cmp++;
        if ({rgb, hsync, vsync, addr_r} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_async: rgb=%h hs=%b vs=%b addr=%0d, want all 0", rgb, hsync, vsync, addr_r);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        act_q.delete(); exp_q.delete();
        repeat (3) step(0, 100, 1'b1, 1'b1, 1'b1, 12'hFFF);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (act_q[i].rgb !== 12'h000 || act_q[i].hs !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_release[%0d]: rgb=%h hs=%b, want 000/0", i, act_q[i].rgb, act_q[i].hs);
            end
        end
        n_cmp++;
        if (act_q[2].rgb !== 12'hFFF || act_q[2].hs !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_valid: rgb=%h hs=%b, want FFF/1", act_q[2].rgb, act_q[2].hs);
        end
        flush();
    endtask

    task automatic test_trace_level();
        int n;
        act_q.delete(); exp_q.delete();
        mem[0] = 1; mem[36] = 1; mem[37] = 1; mem[38] = 0; mem[39] = 0;
        step(0,   100, 1, 0, 0, 12'hFFF);
        step(36,  100, 1, 0, 0, 12'hFFF);
        step(37,  100, 1, 0, 0, 12'hFFF);
        step(38,  200, 1, 0, 0, 12'h0F0);
        step(39,  200, 1, 0, 0, 12'hFFF);
        step(39,  150, 1, 0, 0, 12'h000);
        step(37,  101, 1, 0, 0, 12'h0F0);
        n = exp_q.size();
        flush();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (act_q[i+3].rgb !== exp_q[i].rgb) begin
                n_bad++;
                $display("FAIL trace_rgb[%0d]: got %h want %h", i, act_q[i+3].rgb, exp_q[i].rgb);
            end
            n_cmp++;
            if (act_q[i+1].addr !== exp_q[i].addr) begin
                n_bad++;
                $display("FAIL trace_addr[%0d]: got %0d want %0d", i, act_q[i+1].addr, exp_q[i].addr);
            end
        end
    endtask

    task automatic test_edge();
        int n;
        act_q.delete(); exp_q.delete();
        mem[9] = 0; mem[10] = 0; mem[11] = 0; mem[12] = 1; mem[13] = 1;
        mem[14] = 0; mem[15] = 0; mem[16] = 1; mem[17] = 0;
        step(9,  150, 1, 0, 0, 12'h0F0);
        step(10, 150, 1, 0, 0, 12'h000);
        step(11, 150, 1, 0, 0, 12'h000);
        step(12, 150, 1, 0, 0, 12'h0F0);
        step(13, 150, 1, 0, 0, 12'h000);
        step(14,  99, 1, 0, 0, 12'h000);
        step(15, 201, 1, 0, 0, 12'h000);
        step(16, 100, 1, 0, 0, 12'h0F0);
        step(16, 200, 1, 0, 0, 12'h000);
        step(17, 200, 1, 0, 0, 12'h0F0);
        n = exp_q.size();
        flush();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (act_q[i+3].rgb !== exp_q[i].rgb) begin
                n_bad++;
                $display("FAIL edge_rgb[%0d]: got %h want %h", i, act_q[i+3].rgb, exp_q[i].rgb);
            end
        end
    endtask

    task automatic test_out_of_range();
        int n;
        act_q.delete(); exp_q.delete();
        mem[479] = 1;
        step(500, 100, 1, 0, 0, 12'h000);
        step(480, 100, 1, 0, 0, 12'h000);
        step(479, 200, 1, 0, 0, 12'h0F0);
        step(37,  100, 0, 0, 0, 12'h000);
        step(700,   0, 0, 0, 0, 12'h000);
        n = exp_q.size();
        flush();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (act_q[i+3].rgb !== exp_q[i].rgb) begin
                n_bad++;
                $display("FAIL range_rgb[%0d]: got %h want %h", i, act_q[i+3].rgb, exp_q[i].rgb);
            end
            n_cmp++;
            if (act_q[i+1].addr !== exp_q[i].addr) begin
                n_bad++;
                $display("FAIL range_addr[%0d]: got %0d want %0d", i, act_q[i+1].addr, exp_q[i].addr);
            end
        end
    endtask

    task automatic test_sync();
        int n;
        logic [7:0] hs_pat;
        logic [7:0] vs_pat;
        act_q.delete(); exp_q.delete();
        hs_pat = 8'b0000_0110;
        vs_pat = 8'b0011_1000;
        for (int i = 0; i < 8; i++) step(600, 0, 0, hs_pat[i], vs_pat[i], 12'h000);
        n = exp_q.size();
        flush();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if ({act_q[i+3].hs, act_q[i+3].vs} !== {exp_q[i].hs, exp_q[i].vs}) begin
                n_bad++;
                $display("FAIL sync[%0d]: got hs=%b vs=%b want hs=%b vs=%b", i,
                         act_q[i+3].hs, act_q[i+3].vs, exp_q[i].hs, exp_q[i].vs);
            end
        end
    endtask

    task automatic test_grid();
        int n;
        logic [11:0] g;
`ifdef TRACE_GRID_EN
        g = 12'h333;
`else
        g = 12'h000;
`endif
        act_q.delete(); exp_q.delete();
        mem[64] = 0; mem[63] = 0; mem[96] = 0; mem[32] = 0;
        step(64,  50, 1, 0, 0, g);
        step(64,  51, 1, 0, 0, 12'h000);
        step(63,  50, 1, 0, 0, 12'h000);
        step(96,  50, 1, 0, 0, g);
        step(32, 200, 1, 0, 0, 12'hFFF);
        n = exp_q.size();
        flush();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (act_q[i+3].rgb !== exp_q[i].rgb) begin
                n_bad++;
                $display("FAIL grid_rgb[%0d]: got %h want %h", i, act_q[i+3].rgb, exp_q[i].rgb);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int px;
        int py;
        logic von;
        int ys[7];
        ys = '{50, 99, 100, 150, 200, 201, 300};
        act_q.delete(); exp_q.delete();
        for (int i = 0; i < 512; i++) mem[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 300; i++) begin
            px  = (i % 8 == 7) ? int'($urandom_range(480, 700)) : i;
            py  = ys[$urandom_range(0, 6)];
            von = ($urandom_range(0, 9) != 0);
            step(px, py, von, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 model(px, py, von, (px < 480) ? mem[px] : 1'b0, m_prev));
        end
        n = exp_q.size();
        flush();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (act_q[i+3].rgb !== exp_q[i].rgb ||
                {act_q[i+3].hs, act_q[i+3].vs} !== {exp_q[i].hs, exp_q[i].vs}) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b", i,
                         act_q[i+3].rgb, act_q[i+3].hs, act_q[i+3].vs,
                         exp_q[i].rgb, exp_q[i].hs, exp_q[i].vs);
            end
            n_cmp++;
            if (act_q[i+1].addr !== exp_q[i].addr) begin
                n_bad++;
                $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, act_q[i+1].addr, exp_q[i].addr);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 1'b0;
        test_reset();
        test_trace_level();
        test_edge();
        test_out_of_range();
        test_sync();
        test_grid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
